// File: rtl/maxpool_layer2.sv
// maxpool_layer2: streaming 8-channel max-pooling stage.
// It keeps a running maximum for each channel over POOL accepted beats.
// At the end of each window it loads the result into a registered output
// stage that uses valid/ready backpressure.
//
// Optional feature macro: MAXPOOL2_PARTIAL_FLUSH_EN
//   defined   : in_last before the window is full closes the window early and
//               emits the max of the samples received so far (out_last=1).
//   undefined : a partial trailing window is dropped without output.
//
// Handshake: a beat transfers on a rising edge when in_valid && in_ready.
// A result transfers on a rising edge when out_valid && out_ready.
// A producer holds valid and payload until the transfer. in_ready does not
// depend on in_valid.
//
// dbg_state_o = {output register FULL, accumulator FILLING}.
module maxpool_layer2 #(
    parameter int WIDTH = 8,
    parameter int POOL  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [WIDTH-1:0] Data_in1,
    input  logic [WIDTH-1:0] Data_in2,
    input  logic [WIDTH-1:0] Data_in3,
    input  logic [WIDTH-1:0] Data_in4,
    input  logic [WIDTH-1:0] Data_in5,
    input  logic [WIDTH-1:0] Data_in6,
    input  logic [WIDTH-1:0] Data_in7,
    input  logic [WIDTH-1:0] Data_in8,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [WIDTH-1:0] Data_out1,
    output logic [WIDTH-1:0] Data_out2,
    output logic [WIDTH-1:0] Data_out3,
    output logic [WIDTH-1:0] Data_out4,
    output logic [WIDTH-1:0] Data_out5,
    output logic [WIDTH-1:0] Data_out6,
    output logic [WIDTH-1:0] Data_out7,
    output logic [WIDTH-1:0] Data_out8,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(POOL);
    localparam logic [CW-1:0] CNT_LAST = CW'(POOL - 1);

`ifdef MAXPOOL2_PARTIAL_FLUSH_EN
    localparam bit PARTIAL_FLUSH = 1'b1;
`else
    localparam bit PARTIAL_FLUSH = 1'b0;
`endif

    typedef enum logic {EMPTY_ACC = 1'b0, FILLING = 1'b1} win_state_t;
    typedef enum logic {OUT_EMPTY = 1'b0, OUT_FULL = 1'b1} out_state_t;

    win_state_t       win_state_q, win_state_d;
    out_state_t       out_state_q, out_state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] acc_q  [8];
    logic [WIDTH-1:0] acc_d  [8];
    logic [WIDTH-1:0] dout_q [8];
    logic [WIDTH-1:0] dout_d [8];
    logic [WIDTH-1:0] din    [8];
    logic [WIDTH-1:0] merged [8];

    logic acc_fire;
    logic is_first;
    logic at_end;
    logic close_win;
    logic discard_win;

    assign din[0] = Data_in1;
    assign din[1] = Data_in2;
    assign din[2] = Data_in3;
    assign din[3] = Data_in4;
    assign din[4] = Data_in5;
    assign din[5] = Data_in6;
    assign din[6] = Data_in7;
    assign din[7] = Data_in8;

    // The output register can take a new result when it is empty or when it is draining this cycle.
    assign in_ready    = (out_state_q == OUT_EMPTY) || out_ready;
    assign acc_fire    = in_valid && in_ready;
    assign is_first    = (cnt_q == '0);
    assign at_end      = (cnt_q == CNT_LAST);
    assign close_win   = acc_fire && (at_end || (PARTIAL_FLUSH && in_last));
    assign discard_win = acc_fire && in_last && !at_end && !PARTIAL_FLUSH;

    // Compute the next state of the window counter, the accumulators and the output register.
    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        dout_d      = dout_q;
        out_last_d  = out_last_q;
        out_state_d = out_state_q;
        for (int i = 0; i < 8; i++) begin
            // The first beat of a window replaces the stale accumulator.
            merged[i] = (is_first || (din[i] > acc_q[i])) ? din[i] : acc_q[i];
        end
        if (close_win) begin
            // A reload wins over a drain in the same cycle, so results go out back-to-back.
            dout_d      = merged;
            out_last_d  = in_last;
            out_state_d = OUT_FULL;
            cnt_d       = '0;
        end else begin
            if ((out_state_q == OUT_FULL) && out_ready) begin
                out_state_d = OUT_EMPTY;
            end
            if (discard_win) begin
                cnt_d = '0;
            end else if (acc_fire) begin
                acc_d = merged;
                cnt_d = cnt_q + 1'b1;
            end
        end
        win_state_d = (cnt_d == '0) ? EMPTY_ACC : FILLING;
    end

    // Register the state. Reset drops any partial window and any held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            win_state_q <= EMPTY_ACC;
            out_state_q <= OUT_EMPTY;
            out_last_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                acc_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            cnt_q       <= cnt_d;
            win_state_q <= win_state_d;
            out_state_q <= out_state_d;
            out_last_q  <= out_last_d;
            acc_q       <= acc_d;
            dout_q      <= dout_d;
        end
    end

    assign out_valid   = (out_state_q == OUT_FULL);
    assign out_last    = out_last_q;
    assign Data_out1   = dout_q[0];
    assign Data_out2   = dout_q[1];
    assign Data_out3   = dout_q[2];
    assign Data_out4   = dout_q[3];
    assign Data_out5   = dout_q[4];
    assign Data_out6   = dout_q[5];
    assign Data_out7   = dout_q[6];
    assign Data_out8   = dout_q[7];
    assign dbg_state_o = {out_state_q == OUT_FULL, win_state_q == FILLING};

endmodule

// File: tb/tb_maxpool_layer2.sv
// Testbench for maxpool_layer2. Three instances (POOL = 2, 3, 4) share one
// input stream. A window-level reference model stores the accepted samples of
// each window and reduces them at the close of the window. It predicts every
// result and the cycle in which it is visible.
module tb_maxpool_layer2;

    localparam int NI = 3;  // instance k uses POOL = k + 2

`ifdef MAXPOOL2_PARTIAL_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;
    logic [63:0] din;

    wire [NI-1:0]            rdy;
    wire [NI-1:0]            ovld;
    wire [NI-1:0]            olast;
    wire [NI-1:0][7:0][7:0]  dout;
    wire [NI-1:0][1:0]       dbg;

    int n_checks;
    int n_errors;
    int n_acc [NI];

    logic [63:0] win_q [NI][$];
    logic [64:0] exp_q [NI][$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT instances ----------------
    maxpool_layer2 #(.WIDTH(8), .POOL(2)) u_p2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_last(in_last),
        .Data_in1(din[7:0]), .Data_in2(din[15:8]), .Data_in3(din[23:16]), .Data_in4(din[31:24]),
        .Data_in5(din[39:32]), .Data_in6(din[47:40]), .Data_in7(din[55:48]), .Data_in8(din[63:56]),
        .out_valid(ovld[0]), .out_ready(out_ready), .out_last(olast[0]),
        .Data_out1(dout[0][0]), .Data_out2(dout[0][1]), .Data_out3(dout[0][2]), .Data_out4(dout[0][3]),
        .Data_out5(dout[0][4]), .Data_out6(dout[0][5]), .Data_out7(dout[0][6]), .Data_out8(dout[0][7]),
        .dbg_state_o(dbg[0])
    );

    maxpool_layer2 #(.WIDTH(8), .POOL(3)) u_p3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_last(in_last),
        .Data_in1(din[7:0]), .Data_in2(din[15:8]), .Data_in3(din[23:16]), .Data_in4(din[31:24]),
        .Data_in5(din[39:32]), .Data_in6(din[47:40]), .Data_in7(din[55:48]), .Data_in8(din[63:56]),
        .out_valid(ovld[1]), .out_ready(out_ready), .out_last(olast[1]),
        .Data_out1(dout[1][0]), .Data_out2(dout[1][1]), .Data_out3(dout[1][2]), .Data_out4(dout[1][3]),
        .Data_out5(dout[1][4]), .Data_out6(dout[1][5]), .Data_out7(dout[1][6]), .Data_out8(dout[1][7]),
        .dbg_state_o(dbg[1])
    );

    maxpool_layer2 #(.WIDTH(8), .POOL(4)) u_p4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]), .in_last(in_last),
        .Data_in1(din[7:0]), .Data_in2(din[15:8]), .Data_in3(din[23:16]), .Data_in4(din[31:24]),
        .Data_in5(din[39:32]), .Data_in6(din[47:40]), .Data_in7(din[55:48]), .Data_in8(din[63:56]),
        .out_valid(ovld[2]), .out_ready(out_ready), .out_last(olast[2]),
        .Data_out1(dout[2][0]), .Data_out2(dout[2][1]), .Data_out3(dout[2][2]), .Data_out4(dout[2][3]),
        .Data_out5(dout[2][4]), .Data_out6(dout[2][5]), .Data_out7(dout[2][6]), .Data_out8(dout[2][7]),
        .dbg_state_o(dbg[2])
    );

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] bcast(input logic [7:0] v);
        return {8{v}};
    endfunction

    // Reduce the stored samples of a window to one result, channel by channel.
    function automatic logic [63:0] window_max(input int k);
        logic [63:0] r;
        logic [7:0]  s;
        r = '0;
        for (int c = 0; c < 8; c++) begin
            for (int j = 0; j < win_q[k].size(); j++) begin
                s = win_q[k][j][c*8 +: 8];
                if (j == 0 || s > r[c*8 +: 8]) r[c*8 +: 8] = s;
            end
        end
        return r;
    endfunction

    // ---------------- driver: one clock cycle ----------------
    // Drive the inputs, then check in_ready. Advance the model at the rising
    // edge, then check the outputs at the falling edge.
    task automatic step(input logic v, input logic l, input logic [63:0] d,
                        input logic ordy, input logic r);
        logic mrdy;
        in_valid  = v;
        in_last   = l;
        din       = d;
        out_ready = ordy;
        rst       = r;
        #1;
        if (!r) begin
            for (int k = 0; k < NI; k++)
                check($sformatf("p%0d_in_ready", k + 2), 72'(rdy[k]),
                      72'((exp_q[k].size() == 0) || ordy));
        end
        @(posedge clk);
        for (int k = 0; k < NI; k++) begin
            if (r) begin
                win_q[k].delete();
                exp_q[k].delete();
            end else begin
                mrdy = (exp_q[k].size() == 0) || ordy;
                if (exp_q[k].size() != 0 && ordy) void'(exp_q[k].pop_front());
                if (v && mrdy) begin
                    n_acc[k]++;
                    win_q[k].push_back(d);
                    if (win_q[k].size() == k + 2 || l) begin
                        if (win_q[k].size() == k + 2 || FLUSH)
                            exp_q[k].push_back({l, window_max(k)});
                        win_q[k].delete();
                    end
                end
            end
        end
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("p%0d_out_valid", k + 2), 72'(ovld[k]), 72'(exp_q[k].size() != 0));
            check($sformatf("p%0d_filling", k + 2), 72'(dbg[k][0]), 72'(win_q[k].size() != 0));
            if (exp_q[k].size() != 0)
                check($sformatf("p%0d_result", k + 2), 72'({olast[k], dout[k]}), 72'(exp_q[k][0]));
            else if (r)
                check($sformatf("p%0d_reset_out", k + 2), 72'({olast[k], dout[k]}), 72'(0));
        end
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 64'd0, 1'b1, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] d;
        int cyc;
        n_checks = 0;
        n_errors = 0;
        for (int k = 0; k < NI; k++) n_acc[k] = 0;

        do_reset();
        do_reset();
        check("reset_in_ready", 72'(rdy), 72'(3'b111));

        // Equal channels 3,7,9,2 on the POOL=2 instance: results 7 then 9.
        step(1'b1, 1'b0, bcast(8'd3), 1'b1, 1'b0);
        check("t1_no_early", 72'(ovld[0]), 72'(0));
        step(1'b1, 1'b0, bcast(8'd7), 1'b1, 1'b0);
        check("t1_first", 72'({ovld[0], dout[0][0]}), 72'({1'b1, 8'd7}));
        step(1'b1, 1'b0, bcast(8'd9), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd2), 1'b1, 1'b0);
        check("t1_second", 72'({ovld[0], dout[0][0]}), 72'({1'b1, 8'd9}));

        // Distinct channels. ch1 is (10,4), ch8 is (0,255), ch2 is a 5/5 tie.
        do_reset();
        d = 64'h00_11_22_33_44_55_05_0A;
        step(1'b1, 1'b0, d, 1'b1, 1'b0);
        d = 64'hFF_01_02_03_04_05_05_04;
        step(1'b1, 1'b0, d, 1'b1, 1'b0);
        check("t2_ch1", 72'(dout[0][0]), 72'(8'd10));
        check("t2_ch8", 72'(dout[0][7]), 72'(8'd255));
        check("t2_tie", 72'(dout[0][1]), 72'(8'd5));

        // Backpressure: hold out_ready low for 3 cycles after a result.
        do_reset();
        step(1'b1, 1'b0, bcast(8'd4), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd2), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, bcast(8'd50), 1'b0, 1'b0);
            check("t3_stall_ready", 72'(rdy[0]), 72'(0));
            check("t3_stall_hold", 72'({ovld[0], dout[0][0]}), 72'({1'b1, 8'd4}));
        end
        step(1'b1, 1'b0, bcast(8'd50), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd60), 1'b1, 1'b0);
        check("t3_release", 72'({ovld[0], dout[0][0]}), 72'({1'b1, 8'd60}));

        // POOL=4 with in_last on beat 3 (1,8,2), then a full map.
        do_reset();
        step(1'b1, 1'b0, bcast(8'd1), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd8), 1'b1, 1'b0);
        step(1'b1, 1'b1, bcast(8'd2), 1'b1, 1'b0);
        if (FLUSH)
            check("t4_flush", 72'({ovld[2], olast[2], dout[2][0]}), 72'({1'b1, 1'b1, 8'd8}));
        else
            check("t4_discard", 72'({ovld[2], dbg[2][0]}), 72'(2'b00));
        step(1'b1, 1'b0, bcast(8'd5), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd3), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd4), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd6), 1'b1, 1'b0);
        check("t4_next_map", 72'({ovld[2], olast[2], dout[2][0]}), 72'({1'b1, 1'b0, 8'd6}));

        // Reset in the middle of a window drops the sample from before the reset.
        do_reset();
        step(1'b1, 1'b0, bcast(8'd9), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd9), 1'b1, 1'b1);
        check("t5_reset_out", 72'({ovld[0], dout[0][0]}), 72'(0));
        step(1'b1, 1'b0, bcast(8'd6), 1'b1, 1'b0);
        step(1'b1, 1'b0, bcast(8'd1), 1'b1, 1'b0);
        check("t5_after_reset", 72'({ovld[0], dout[0][0]}), 72'({1'b1, 8'd6}));

        // Random traffic until the POOL=3 instance has taken 1000 beats.
        do_reset();
        for (int k = 0; k < NI; k++) n_acc[k] = 0;
        cyc = 0;
        while (n_acc[1] < 1000 && cyc < 6000) begin
            for (int c = 0; c < 8; c++)
                d[c*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                          : 8'($urandom_range(0, 255));
            step(($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0), d,
                 ($urandom_range(0, 9) < 7), 1'b0);
            cyc++;
        end
        check("random_beats_done", 72'(n_acc[1] >= 1000), 72'(1));

        // Drain the held results.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
        check("drained", 72'(ovld), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/maxpool_layer2.md
# maxpool_layer2

Streaming max-pooling stage placed directly after the 8-channel layer-2 ReLU. Each input beat carries one sample per channel; the block keeps a running per-channel maximum over POOL consecutive accepted beats and emits one 8-channel result per window. Results are held in a registered output stage with valid/ready backpressure. The block feeds the next convolution or flatten stage.

## Interface
- WIDTH, 8: bit width of every channel sample, input and output.
- POOL, 2: window length in beats, and the stride (non-overlapping windows). Legal range 2..8.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_last  input  1  marks the final beat of a feature map. Sampled only on an accepted beat.
- Data_in1..Data_in8  input  WIDTH each  ReLU outputs. Unsigned, non-negative.
- out_valid  output  1  pooled result present.
- out_ready  input  1  downstream accepts the result.
- out_last  output  1  result is the final window of the feature map.
- Data_out1..Data_out8  output  WIDTH each  per-channel window maximum.

## Operation
- Accept: acc = in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational and allows one beat per cycle at full throughput.
- cnt is a window counter, 0..POOL-1. It is reset to 0.
- acc_r1..acc_r8 are per-channel accumulators.
- On an accepted beat with cnt==0, and no window closing: acc_rN <= Data_inN, and cnt <= 1.
- On an accepted beat with 0<cnt<POOL-1, and not in_last: acc_rN <= max(acc_rN, Data_inN), and cnt <= cnt+1.
- A window closes on an accepted beat when either of these holds:
  - cnt==POOL-1;
  - in_last=1, and the partial flush feature is enabled (see Configuration).
- When a window closes:
  - Data_outN <= max(acc_rN, Data_inN), or Data_inN alone when cnt==0;
  - out_last <= in_last;
  - out_valid <= 1;
  - cnt <= 0.
- The max comparison is an unsigned WIDTH-bit compare. On ties, either operand may be taken; the output value is identical.
- State view:
  - EMPTY_ACC: cnt==0.
  - FILLING: cnt>0.
  - Output register is either FULL or EMPTY.
  - The two are independent. The accumulator continues filling while the output is FULL, as long as in_ready is high.
- Output handshake:
  - out_valid clears on out_valid && out_ready, unless a new window closes in the same cycle. In that case the register reloads and out_valid stays 1.
  - While out_valid=1 and out_ready=0, Data_outN and out_last are held stable. in_ready=0 in that state.
- in_last with cnt==POOL-1 is a normal window close with out_last=1.
- After any close on in_last, cnt returns to 0 for the next feature map.

## Timing
- Reset (rst=1 at a clk edge) values:
  - out_valid=0, out_last=0, Data_out1..8=0;
  - cnt=0, acc_r1..8=0.
  - in_ready therefore reads 1 in the cycle after reset.
- Reset mid-window discards the partial accumulation and any held result. No output is produced for them.
- Latency: out_valid rises on the clock edge that accepts the window-closing beat. The result is visible one cycle after that beat is presented.
- Throughput: one window per POOL accepted beats, with zero bubbles when out_ready is held at 1.
- Simultaneous output drain and new window close: reload takes priority. The result is sent back-to-back with no gap.
- in_valid low mid-window: cnt and acc_r hold indefinitely.

## Configuration
- Macro: MAXPOOL2_PARTIAL_FLUSH_EN.
- Defined:
  - in_last on an accepted beat with cnt<POOL-1 closes the window early.
  - It emits the max of the samples received so far, with out_last=1.
- Undefined:
  - in_last only affects out_last when it falls on cnt==POOL-1.
  - A partial trailing window is silently discarded, and cnt resets to 0.
  - No output is produced for it.

## Test plan
- POOL=2, out_ready=1, beats ch1 = 3,7,9,2 (all channels equal) -> two results: 7 then 9, one cycle after beats 2 and 4. No in_ready drop.
- POOL=2, 8 distinct channel streams; ch1 (10,4), ch8 (0,255) -> Data_out1=10, Data_out8=255. Tie case (5,5) -> 5.
- POOL=2, out_ready=0 for 3 cycles after the first result -> Data_out and out_valid held stable, in_ready=0, no beat accepted. Release -> next window accepted, result 1 cycle later.
- POOL=4, in_last on beat 3, values 1,8,2 -> MAXPOOL2_PARTIAL_FLUSH_EN defined: output 8 with out_last=1. Undefined: no output and cnt=0. The next map's first window is correct.
- rst asserted after 1 beat of a POOL=2 window -> out_valid=0, all outputs 0. The next 2 beats (6,1) produce 6, not including the pre-reset sample.
- Random in_valid/out_ready, 1000 beats, POOL=3 -> output sequence matches the reference model exactly. No lost or duplicated windows.
